// File: rtl/seg7_reader.sv
// Seven-segment pattern reader: debounces an active-low segment bus, decodes the
// stable pattern to a hex digit and hands it off over valid/ready with a short history.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         seg,
  input  logic               seg_valid,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [3:0]         digit,
  output logic               err,
  output logic [15:0]        history,
  output logic [COUNT_W-1:0] digit_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_t     state;
  logic [6:0] cand;
  logic [3:0] stab_cnt;
  logic       last_ok;
  logic [6:0] last_seg;

  logic       restart;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic [4:0] dec;

  // Returns {err, digit}; illegal patterns decode to err with digit 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h00;
      7'h79:   decode = 5'h01;
      7'h24:   decode = 5'h02;
      7'h30:   decode = 5'h03;
      7'h19:   decode = 5'h04;
      7'h12:   decode = 5'h05;
      7'h02:   decode = 5'h06;
      7'h78:   decode = 5'h07;
      7'h00:   decode = 5'h08;
      7'h18:   decode = 5'h09;
      7'h08:   decode = 5'h0A;
      7'h03:   decode = 5'h0B;
      7'h46:   decode = 5'h0C;
      7'h21:   decode = 5'h0D;
      7'h06:   decode = 5'h0E;
      7'h0E:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    restart = 1'b0;
    cnt_nxt = stab_cnt;
    accept  = 1'b0;
    dec     = decode(seg);

    restart = (seg != cand) || (stab_cnt == 4'd0);
    if (restart)
      cnt_nxt = 4'd1;
    else if (stab_cnt < STABLE)
      cnt_nxt = stab_cnt + 4'd1;

    // Fire only on the cycle the count arrives at STABLE, never while it sits saturated.
    accept = seg_valid && (cnt_nxt == STABLE) && (restart || (stab_cnt < STABLE)) &&
             (!last_ok || (seg != last_seg));
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      digit       <= 4'd0;
      err         <= 1'b0;
      // NOTE: the history shift register is reset explicitly; it is visible on a port.
      history     <= 16'd0;
      digit_count <= '0;
      cand        <= 7'd0;
      stab_cnt    <= 4'd0;
      last_ok     <= 1'b0;
      last_seg    <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!seg_valid) begin
            stab_cnt <= 4'd0;
            last_ok  <= 1'b0;
          end else begin
            cand     <= seg;
            stab_cnt <= cnt_nxt;
            if (accept) begin
              err       <= dec[4];
              digit     <= dec[3:0];
              out_valid <= 1'b1;
              state     <= EMIT;
              last_ok   <= 1'b1;
              last_seg  <= seg;
            end
          end
        end
        EMIT: begin
          if (!seg_valid)
            last_ok <= 1'b0;
          if (out_ready) begin
            out_valid <= 1'b0;
            stab_cnt  <= 4'd0;
            state     <= IDLE;
            if (!err) begin
              history     <= {history[11:0], digit};
              digit_count <= digit_count + COUNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: a sample-window model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_seg7_reader;
  localparam int S  = 4;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seg = 7'd0;
  logic          seg_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [3:0]    digit;
  logic          err;
  logic [15:0]   history;
  logic [CW-1:0] digit_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  seg7_reader #(.STABLE_CYCLES(S), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .seg(seg), .seg_valid(seg_valid), .out_ready(out_ready),
    .out_valid(out_valid), .digit(digit), .err(err), .history(history),
    .digit_count(digit_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0]  samples [$];
  bit          m_valid, m_err, m_last_ok;
  logic [3:0]  m_digit;
  logic [6:0]  m_last_seg;
  logic [15:0] m_hist;
  int          m_count;

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) return i;
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      samples.delete();
      m_valid = 0; m_err = 0; m_last_ok = 0;
      m_digit = 4'd0; m_last_seg = 7'd0; m_hist = 16'd0; m_count = 0;
    end else if (m_valid) begin
      if (!seg_valid) m_last_ok = 0;
      if (out_ready) begin
        m_valid = 0;
        samples.delete();
        if (!m_err) begin
          m_hist  = (m_hist << 4) | 16'(m_digit);
          m_count = (m_count + 1) % (1 << CW);
        end
      end
    end else if (!seg_valid) begin
      samples.delete();
      m_last_ok = 0;
    end else begin
      int run;
      int code;
      samples.push_back(seg);
      while (samples.size() > S + 1) void'(samples.pop_front());
      run = 0;
      for (int i = samples.size() - 1; i >= 0; i--) begin
        if (samples[i] != seg) break;
        run++;
      end
      if (run == S && (!m_last_ok || seg != m_last_seg)) begin
        code       = lookup(seg);
        m_valid    = 1;
        m_err      = (code < 0);
        m_digit    = (code < 0) ? 4'd0 : 4'(code);
        m_last_ok  = 1;
        m_last_seg = seg;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model history", 32'(history), 32'(m_hist));
      check("model digit_count", 32'(digit_count), 32'(m_count));
      if (m_valid) begin
        check("model digit", 32'(digit), 32'(m_digit));
        check("model err", 32'(err), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [6:0] s, input logic v, input logic r);
    seg = s; seg_valid = v; out_ready = r;
    @(negedge clock);
  endtask

  task automatic hold(input logic [6:0] s, input logic v, input logic r, input int n);
    repeat (n) cyc(s, v, r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " digit"}, 32'(digit), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " history"}, 32'(history), 32'd0);
    check({tag, " digit_count"}, 32'(digit_count), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(7'h00, 1'b0, 1'b0);
    reset = 1'b0;
    cmp_en = 1;
    check_zero("reset");
  endtask

  initial begin
    int seen;

    // Basic latency, handshake, and single emission while held
    do_reset();
    hold(7'h30, 1'b1, 1'b0, 3);
    check("s1 not yet valid", 32'(out_valid), 32'd0);
    cyc(7'h30, 1'b1, 1'b0);
    check("s1 valid at cycle 4", 32'(out_valid), 32'd1);
    check("s1 digit", 32'(digit), 32'h3);
    check("s1 err", 32'(err), 32'd0);
    cyc(7'h30, 1'b1, 1'b1);
    check("s1 valid drops", 32'(out_valid), 32'd0);
    check("s1 history", 32'(history), 32'h0003);
    check("s1 count", 32'(digit_count), 32'd1);
    seen = 0;
    repeat (12) begin
      cyc(7'h30, 1'b1, 1'b1);
      if (out_valid) seen++;
    end
    check("s1 no re-emission", 32'(seen), 32'd0);

    // Glitch restarts the stability count
    do_reset();
    hold(7'h12, 1'b1, 1'b0, 3);
    cyc(7'h02, 1'b1, 1'b0);
    check("s2 glitch no valid", 32'(out_valid), 32'd0);
    hold(7'h12, 1'b1, 1'b0, 3);
    check("s2 still counting", 32'(out_valid), 32'd0);
    cyc(7'h12, 1'b1, 1'b0);
    check("s2 valid", 32'(out_valid), 32'd1);
    check("s2 digit", 32'(digit), 32'h5);
    cyc(7'h12, 1'b0, 1'b1);
    check("s2 history", 32'(history), 32'h0005);
    check("s2 count", 32'(digit_count), 32'd1);

    // Illegal pattern
    hold(7'h7F, 1'b1, 1'b0, 4);
    check("s3 valid", 32'(out_valid), 32'd1);
    check("s3 err", 32'(err), 32'd1);
    check("s3 digit", 32'(digit), 32'd0);
    cyc(7'h7F, 1'b0, 1'b1);
    check("s3 history kept", 32'(history), 32'h0005);
    check("s3 count kept", 32'(digit_count), 32'd1);

    // Backpressure holds the emitted digit while seg changes
    do_reset();
    hold(7'h46, 1'b1, 1'b0, 4);
    check("s4 valid C", 32'(out_valid), 32'd1);
    hold(7'h21, 1'b1, 1'b0, 10);
    check("s4 digit held", 32'(digit), 32'hC);
    check("s4 still valid", 32'(out_valid), 32'd1);
    cyc(7'h21, 1'b1, 1'b1);
    hold(7'h21, 1'b1, 1'b0, 3);
    check("s4 fresh count", 32'(out_valid), 32'd0);
    cyc(7'h21, 1'b1, 1'b0);
    check("s4 digit d", 32'(digit), 32'hD);
    cyc(7'h21, 1'b0, 1'b1);
    check("s4 history", 32'(history), 32'h00CD);

    // Same digit twice, separated by a seg_valid gap
    do_reset();
    hold(7'h00, 1'b1, 1'b0, 4);
    check("s5 first 8", 32'(digit), 32'h8);
    cyc(7'h00, 1'b1, 1'b1);
    cyc(7'h00, 1'b0, 1'b0);
    hold(7'h00, 1'b1, 1'b0, 4);
    check("s5 second valid", 32'(out_valid), 32'd1);
    cyc(7'h00, 1'b0, 1'b1);
    check("s5 history", 32'(history), 32'h0088);
    check("s5 count", 32'(digit_count), 32'd2);

    // Reset while emitting, and mid-count
    do_reset();
    hold(7'h79, 1'b1, 1'b0, 4);
    check("s6 in emit", 32'(out_valid), 32'd1);
    reset = 1'b1;
    cyc(7'h79, 1'b1, 1'b0);
    reset = 1'b0;
    check_zero("s6 reset in emit");
    hold(7'h79, 1'b1, 1'b0, 3);
    reset = 1'b1;
    cyc(7'h79, 1'b1, 1'b0);
    reset = 1'b0;
    check_zero("s6 reset mid count");
    hold(7'h79, 1'b1, 1'b0, 3);
    check("s6 full hold needed", 32'(out_valid), 32'd0);
    cyc(7'h79, 1'b1, 1'b0);
    check("s6 valid", 32'(out_valid), 32'd1);
    check("s6 digit", 32'(digit), 32'h1);
    cyc(7'h79, 1'b1, 1'b1);

    // Counter wrap after 2^COUNT_W good transfers
    do_reset();
    for (int i = 0; i < (1 << CW); i++) begin
      logic [6:0] s;
      s = (i % 2 == 1) ? 7'h24 : 7'h79;
      hold(s, 1'b1, 1'b0, S);
      cyc(s, 1'b1, 1'b1);
    end
    check("wrap count", 32'(digit_count), 32'd0);
    check("wrap history", 32'(history), 32'h1212);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
